// File: rtl/mfu_pkg.sv
// Shared mode encodings, lane geometry and FSM state type for the MFU drain.
package mfu_pkg;

  localparam logic [1:0] MODE_2BX2B = 2'b00;
  localparam logic [1:0] MODE_4BX4B = 2'b01;
  localparam logic [1:0] MODE_8BX8B = 2'b10;
  localparam logic [1:0] MODE_INV   = 2'b11;

  // Per-mode lane widths
  localparam int LANE_W_2B = 8;
  localparam int LANE_W_4B = 12;
  localparam int LANE_W_8B = 20;

  // Per-mode lane counts
  localparam int NLANES_2B = 16;
  localparam int NLANES_4B = 4;
  localparam int NLANES_8B = 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // Index of the final lane for a given mode; invalid mode maps to lane 0.
  function automatic logic [3:0] last_lane(input logic [1:0] m);
    case (m)
      MODE_2BX2B: last_lane = 4'(NLANES_2B - 1);
      MODE_4BX4B: last_lane = 4'(NLANES_4B - 1);
      MODE_8BX8B: last_lane = 4'(NLANES_8B - 1);
      default:    last_lane = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/mfu_lane_sel.sv
// Combinational lane picker: slices one lane out of the latched accumulator
// vector and sign-extends it to the output word width.
module mfu_lane_sel
  import mfu_pkg::*;
#(
  parameter int SUM_W = 128,
  parameter int OUT_W = 20
) (
  input  logic [SUM_W-1:0] sum,
  input  logic [1:0]       mode,
  input  logic [3:0]       lane,
  output logic [OUT_W-1:0] word
);

  logic [NLANES_2B-1:0][OUT_W-1:0] w2;
  logic [NLANES_4B-1:0][OUT_W-1:0] w4;

  // Pre-extend every candidate lane; the mux below just picks one.
  for (genvar g = 0; g < NLANES_2B; g++) begin : g_l2
    assign w2[g] = {{(OUT_W-LANE_W_2B){sum[LANE_W_2B*g+LANE_W_2B-1]}},
                    sum[LANE_W_2B*g +: LANE_W_2B]};
  end

  for (genvar g = 0; g < NLANES_4B; g++) begin : g_l4
    assign w4[g] = {{(OUT_W-LANE_W_4B){sum[LANE_W_4B*g+LANE_W_4B-1]}},
                    sum[LANE_W_4B*g +: LANE_W_4B]};
  end

  // Mode-driven lane mux; the full-width lane passes straight through.
  always_comb begin
    word = '0;
    case (mode)
      MODE_2BX2B: word = w2[lane];
      MODE_4BX4B: word = w4[lane[1:0]];
      MODE_8BX8B: word = sum[OUT_W-1:0];
      default:    word = '0;
    endcase
  end

endmodule

// File: rtl/mfu_drain.sv
// Captures a packed accumulator vector and drains it lane by lane over a
// valid/ready stream, lane 0 first.
module mfu_drain
  import mfu_pkg::*;
#(
  parameter int SUM_W = 128,
  parameter int OUT_W = 20
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [SUM_W-1:0] sum,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic             start_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [3:0]       out_lane,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);

  state_t           state, nxt;
  logic [SUM_W-1:0] sum_q;
  logic [1:0]       mode_q;
  logic [3:0]       lane_q;
  logic             err_q;
  logic             accept, err_set, hs, is_last;
  logic [OUT_W-1:0] word;

  assign is_last = (lane_q == last_lane(mode_q));

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next state plus capture/handshake strobes; live inputs only matter in IDLE.
  always_comb begin
    nxt     = state;
    accept  = 1'b0;
    err_set = 1'b0;
    hs      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (mode == MODE_INV) begin
            err_set = 1'b1;
          end else begin
            accept = 1'b1;
            nxt    = S_SEND;
          end
        end
      end
      S_SEND: begin
        if (out_ready) begin
          hs = 1'b1;
          if (is_last) nxt = S_IDLE;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Capture registers, lane counter and the registered error pulse.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sum_q  <= '0;
      mode_q <= MODE_INV;
      lane_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= err_set;
      if (accept) begin
        sum_q  <= sum;
        mode_q <= mode;
        lane_q <= '0;
      end else if (hs) begin
        // Wrap to 0 on the last beat so out_lane idles at 0.
        lane_q <= is_last ? 4'd0 : lane_q + 4'd1;
      end
    end
  end

  mfu_lane_sel #(.SUM_W(SUM_W), .OUT_W(OUT_W)) u_sel (
    .sum  (sum_q),
    .mode (mode_q),
    .lane (lane_q),
    .word (word)
  );

  assign out_valid   = (state == S_SEND);
  assign start_ready = (state == S_IDLE);
  assign out_lane    = lane_q;
  assign out_last    = out_valid && is_last;
  assign out_data    = out_valid ? word : '0;
  assign err         = err_q;

endmodule
